// File: rtl/bch15_pkg.sv
// ----------------------------------------------------------------------------
// bch15_pkg
// Shared constants and types for the BCH(15,7) double-error-correcting decoder:
// code geometry, GF(16) field polynomial (x^4+x+1), generator polynomial,
// sequencer state encoding, the alpha powers used by the serial datapath, and
// a constant GF(16) inverse table.
// ----------------------------------------------------------------------------
package bch15_pkg;

    localparam int          N          = 15;
    localparam int          K          = 7;
    localparam logic [4:0]  FIELD_POLY = 5'b10011;
    localparam logic [8:0]  GEN_POLY   = 9'h1D1;

    typedef logic [3:0] gf16_t;

    localparam gf16_t ALPHA      = 4'h2;   // alpha
    localparam gf16_t ALPHA3     = 4'h8;   // alpha^3
    localparam gf16_t ALPHA_INV  = 4'h9;   // alpha^-1 = alpha^14
    localparam gf16_t ALPHA_INV2 = 4'hD;   // alpha^-2 = alpha^13

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYND  = 3'd1,
        SOLVE = 3'd2,
        CHIEN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Multiplicative inverse; 0 maps to 0 (never used, S1=0 is handled apart).
    function automatic gf16_t gf16_inv(input gf16_t x);
        case (x)
            4'h1:    gf16_inv = 4'h1;
            4'h2:    gf16_inv = 4'h9;
            4'h3:    gf16_inv = 4'hE;
            4'h4:    gf16_inv = 4'hD;
            4'h5:    gf16_inv = 4'hB;
            4'h6:    gf16_inv = 4'h7;
            4'h7:    gf16_inv = 4'h6;
            4'h8:    gf16_inv = 4'hF;
            4'h9:    gf16_inv = 4'h2;
            4'hA:    gf16_inv = 4'hC;
            4'hB:    gf16_inv = 4'h5;
            4'hC:    gf16_inv = 4'hA;
            4'hD:    gf16_inv = 4'h4;
            4'hE:    gf16_inv = 4'h3;
            4'hF:    gf16_inv = 4'h8;
            default: gf16_inv = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/bch_gf16_mul.sv
// ----------------------------------------------------------------------------
// bch_gf16_mul
// Combinational GF(16) multiplier over x^4+x+1.
// Ports: a_i, b_i - operands; p_o - product a_i*b_i.
// ----------------------------------------------------------------------------
module bch_gf16_mul
    import bch15_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);

    logic [6:0] prod;

    always_comb begin
        prod = '0;
        // Carry-less product, then fold degrees 6..4 back with the field poly.
        for (int i = 0; i < 4; i++)
            if (b_i[i]) prod = prod ^ ({3'b000, a_i} << i);
        for (int i = 6; i >= 4; i--)
            if (prod[i]) prod = prod ^ (7'(FIELD_POLY) << (i - 4));
        p_o = prod[3:0];
    end

endmodule

// File: rtl/bch_dec_seq_ctrl.sv
// ----------------------------------------------------------------------------
// bch_dec_seq_ctrl
// Multi-cycle BCH(15,7) decoder sequencer: bit-serial syndromes S1/S3,
// single-cycle error-locator solve, serial Chien search with in-place bit
// correction, result held under valid/ready backpressure.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data   received-word handshake (bit i = x^i)
//   out_valid/out_ready         result handshake
//   out_codeword, out_message   corrected word and its [14:8] message bits
//   out_err_cnt, out_uncorr     corrections made / uncorrectable flag
//   corr_cnt, uncorr_cnt        saturating statistics counters
// Optional: BCH_DEC_SEQ_CTRL_FAST_CLEAN_EN - zero-syndrome words skip CHIEN.
// ----------------------------------------------------------------------------
module bch_dec_seq_ctrl
    import bch15_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_codeword,
    output logic [6:0]       out_message,
    output logic [1:0]       out_err_cnt,
    output logic             out_uncorr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    state_t          state_q, state_d;
    logic [14:0]     rx_q, word_q;
    gf16_t           s1_q, s3_q, t1_q, t2_q;
    logic [3:0]      idx_q;
    logic [1:0]      deg_q, roots_q;
    logic            bad_q;
    logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

    gf16_t s1a, s3a, s1sq, s1cube, sig2, t1n, t2n, chien_sum;
    logic  r_bit, clean, single;

    bch_gf16_mul u_s1a  (.a_i(s1_q),          .b_i(ALPHA),        .p_o(s1a));
    bch_gf16_mul u_s3a  (.a_i(s3_q),          .b_i(ALPHA3),       .p_o(s3a));
    bch_gf16_mul u_sq   (.a_i(s1_q),          .b_i(s1_q),         .p_o(s1sq));
    bch_gf16_mul u_cube (.a_i(s1sq),          .b_i(s1_q),         .p_o(s1cube));
    bch_gf16_mul u_sig2 (.a_i(s3_q ^ s1cube), .b_i(gf16_inv(s1_q)), .p_o(sig2));
    bch_gf16_mul u_t1   (.a_i(t1_q),          .b_i(ALPHA_INV),    .p_o(t1n));
    bch_gf16_mul u_t2   (.a_i(t2_q),          .b_i(ALPHA_INV2),   .p_o(t2n));

    assign r_bit     = rx_q[idx_q];
    assign clean     = (s1_q == 4'h0) && (s3_q == 4'h0);
    assign single    = (s3_q == s1cube);
    assign chien_sum = 4'h1 ^ t1_q ^ t2_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid)      state_d = SYND;
            SYND:  if (idx_q == 4'd0) state_d = SOLVE;
`ifdef BCH_DEC_SEQ_CTRL_FAST_CLEAN_EN
            SOLVE: state_d = clean ? DONE : CHIEN;
`else
            SOLVE: state_d = CHIEN;
`endif
            CHIEN: if (idx_q == 4'd14) state_d = DONE;
            DONE:  if (out_ready)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; everything but the counters reads zero outside DONE.
    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = 1'b0;
        out_codeword = '0;
        out_err_cnt  = '0;
        out_uncorr   = 1'b0;
        if (state_q == DONE) begin
            out_valid = 1'b1;
            if (bad_q || (roots_q != deg_q)) begin
                out_uncorr   = 1'b1;
                out_codeword = rx_q;
            end else begin
                out_codeword = word_q;
                out_err_cnt  = roots_q;
            end
        end
    end

    assign out_message = out_codeword[14:8];
    assign corr_cnt    = corr_cnt_q;
    assign uncorr_cnt  = uncorr_cnt_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q         <= '0;
            word_q       <= '0;
            s1_q         <= '0;
            s3_q         <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            idx_q        <= '0;
            deg_q        <= '0;
            roots_q      <= '0;
            bad_q        <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    rx_q    <= in_data;
                    word_q  <= in_data;
                    s1_q    <= '0;
                    s3_q    <= '0;
                    idx_q   <= 4'd14;
                    deg_q   <= '0;
                    roots_q <= '0;
                    bad_q   <= 1'b0;
                end
                SYND: begin
                    // Horner evaluation of r(alpha) and r(alpha^3), MSB first
                    s1_q <= s1a ^ {3'b000, r_bit};
                    s3_q <= s3a ^ {3'b000, r_bit};
                    if (idx_q != 4'd0) idx_q <= idx_q - 4'd1;
                end
                SOLVE: begin
                    idx_q <= 4'd0;
                    t1_q  <= s1_q;
                    t2_q  <= '0;
                    deg_q <= 2'd0;
                    if (s1_q == 4'h0) begin
                        t1_q  <= '0;
                        bad_q <= !clean;   // S3 alone nonzero: >2 errors
                    end else if (single) begin
                        deg_q <= 2'd1;
                    end else begin
                        t2_q  <= sig2;
                        deg_q <= 2'd2;
                    end
                end
                CHIEN: begin
                    // sigma(alpha^-i) == 0 marks bit i as an error location
                    if (chien_sum == 4'h0) begin
                        word_q[idx_q] <= ~word_q[idx_q];
                        roots_q       <= roots_q + 2'd1;
                    end
                    t1_q  <= t1n;
                    t2_q  <= t2n;
                    idx_q <= idx_q + 4'd1;
                end
                DONE: if (out_ready) begin
                    if (out_err_cnt != 2'd0 && corr_cnt_q != '1)
                        corr_cnt_q <= corr_cnt_q + CNT_W'(1);
                    if (out_uncorr && uncorr_cnt_q != '1)
                        uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_dec_seq_ctrl.sv
module tb_bch_dec_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_codeword;
    logic [6:0]  out_message;
    logic [1:0]  out_err_cnt;
    logic        out_uncorr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    bch_dec_seq_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_codeword(out_codeword), .out_message(out_message),
        .out_err_cnt(out_err_cnt), .out_uncorr(out_uncorr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word, measure latency to out_valid, optionally stall the
    // consumer for 'hold' cycles with ignored in_valid pulses, then complete
    // the output handshake and check the counters afterwards.
    task automatic run_word(input string tag, input logic [14:0] data, input int exp_lat,
                            input logic [14:0] exp_cw, input logic [1:0] exp_err,
                            input logic exp_unc, input int exp_corr, input int exp_uncc,
                            input int hold);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 15'h7FFF;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"},  lat,          exp_lat);
        check({tag, "_codeword"}, out_codeword, exp_cw);
        check({tag, "_message"},  out_message,  exp_cw[14:8]);
        check({tag, "_err_cnt"},  out_err_cnt,  exp_err);
        check({tag, "_uncorr"},   out_uncorr,   exp_unc);
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            in_data  = 15'h4001;
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid,    1);
            check({tag, "_hold_cw"},    out_codeword, exp_cw);
            check({tag, "_hold_ready"}, in_ready,     0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_in_ready"},  in_ready,   1);
        check({tag, "_post_out_valid"}, out_valid,  0);
        check({tag, "_corr_cnt"},       corr_cnt,   exp_corr);
        check({tag, "_uncorr_cnt"},     uncorr_cnt, exp_uncc);
    endtask

    initial begin
        int clean_lat;
`ifdef BCH_DEC_SEQ_CTRL_FAST_CLEAN_EN
        clean_lat = 17;
`else
        clean_lat = 32;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready,     1);
        check("rst_out_valid", out_valid,    0);
        check("rst_codeword",  out_codeword, 0);
        check("rst_err_cnt",   out_err_cnt,  0);
        check("rst_uncorr",    out_uncorr,   0);
        check("rst_corr",      corr_cnt,     0);
        check("rst_uncorr_c",  uncorr_cnt,   0);
        rst = 1'b0;

        run_word("zero",   15'h0000, clean_lat, 15'h0000, 2'd0, 1'b0, 0, 0, 0);
        run_word("single", 15'h41D1, 32,        15'h01D1, 2'd1, 1'b0, 1, 0, 0);
        run_word("double", 15'h4001, 32,        15'h0000, 2'd2, 1'b0, 2, 0, 0);
        run_word("uncorr", 15'h0013, 32,        15'h0013, 2'd0, 1'b1, 2, 1, 0);
        run_word("hold",   15'h01D9, 32,        15'h01D1, 2'd1, 1'b0, 3, 1, 10);

        // Released with in_valid low: must stay idle, no second handshake.
        repeat (3) @(negedge clk);
        check("idle_in_ready",  in_ready,  1);
        check("idle_out_valid", out_valid, 0);
        check("idle_corr",      corr_cnt,  3);

        // Reset in the middle of a decode.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 15'h4001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready",  in_ready,     1);
        check("mid_rst_out_valid", out_valid,    0);
        check("mid_rst_codeword",  out_codeword, 0);
        check("mid_rst_corr",      corr_cnt,     0);
        check("mid_rst_uncorr",    uncorr_cnt,   0);

        run_word("after_rst", 15'h41D1, 32, 15'h01D1, 2'd1, 1'b0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
